// File: rtl/spu_pkg.sv
// Shared widths, unit encoding and the registered decode bundle for the odd-pipe front end.
package spu_pkg;

  localparam int unsigned REG_ADDR_W = 7;
  localparam int unsigned NUM_REGS   = 128;
  localparam int unsigned DATA_W     = 128;
  localparam int unsigned OP_W       = 11;
  localparam int unsigned FMT_W      = 3;
  localparam int unsigned UNIT_W     = 2;
  localparam int unsigned IMM_W      = 18;
  localparam int unsigned FWD_DEPTH  = 7;

  typedef enum logic [UNIT_W-1:0] {
    UNIT_PERM = 2'd0,
    UNIT_LS   = 2'd1,
    UNIT_BR   = 2'd2
  } odd_unit_t;

  typedef struct packed {
    logic [OP_W-1:0]       op;
    logic [FMT_W-1:0]      format;
    odd_unit_t             unit;
    logic [REG_ADDR_W-1:0] rt_addr;
    logic [IMM_W-1:0]      imm;
    logic                  reg_write;
  } odd_bundle_t;

endpackage

// File: rtl/fwd_select.sv
// Resolves one source register against the forwarding chain, the WB bypass and the RF.
// ODD_FWD_EN enables the forwarding chain; without it only WB bypass and RF are used.
module fwd_select
  import spu_pkg::*;
(
  input  logic [REG_ADDR_W-1:0]           addr_i,
  input  logic [FWD_DEPTH*DATA_W-1:0]     fw_wb_i,
  input  logic [FWD_DEPTH*REG_ADDR_W-1:0] fw_addr_wb_i,
  input  logic [FWD_DEPTH-1:0]            fw_write_wb_i,
  input  logic [DATA_W-1:0]               wb_data_i,
  input  logic [REG_ADDR_W-1:0]           wb_addr_i,
  input  logic                            wb_write_i,
  input  logic [DATA_W-1:0]               rf_data_i,
  output logic [DATA_W-1:0]               data_c
);

`ifndef ODD_FWD_EN
  logic fw_unused_c;
  assign fw_unused_c = ^{fw_wb_i, fw_addr_wb_i, fw_write_wb_i};
`endif

  // Lowest priority first; later assignments win, oldest fw entry first so index 0 wins.
  always_comb begin
    data_c = rf_data_i;
    if (wb_write_i && (wb_addr_i == addr_i)) begin
      data_c = wb_data_i;
    end
`ifdef ODD_FWD_EN
    for (int i = int'(FWD_DEPTH) - 1; i >= 0; i--) begin
      if (fw_write_wb_i[i] && (fw_addr_wb_i[i*REG_ADDR_W +: REG_ADDR_W] == addr_i)) begin
        data_c = fw_wb_i[i*DATA_W +: DATA_W];
      end
    end
`endif
  end

endmodule

// File: rtl/odd_operand_fetch.sv
// Odd-pipe register fetch / forward stage: 128x128 RF, operand resolution, stallable output bundle.
// Build with ODD_FWD_EN to resolve operands against the forwarding staging chain.
module odd_operand_fetch
  import spu_pkg::*;
(
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            in_valid,
  input  logic                            stall,
  input  logic [OP_W-1:0]                 op,
  input  logic [FMT_W-1:0]                format,
  input  logic [UNIT_W-1:0]               unit,
  input  logic [REG_ADDR_W-1:0]           rt_addr,
  input  logic [REG_ADDR_W-1:0]           ra_addr,
  input  logic [REG_ADDR_W-1:0]           rb_addr,
  input  logic [REG_ADDR_W-1:0]           rc_addr,
  input  logic [IMM_W-1:0]                imm,
  input  logic                            reg_write,
  input  logic [FWD_DEPTH*DATA_W-1:0]     fw_wb,
  input  logic [FWD_DEPTH*REG_ADDR_W-1:0] fw_addr_wb,
  input  logic [FWD_DEPTH-1:0]            fw_write_wb,
  input  logic [DATA_W-1:0]               wb_data,
  input  logic [REG_ADDR_W-1:0]           wb_addr,
  input  logic                            wb_write,
  output logic [OP_W-1:0]                 op_q,
  output logic [FMT_W-1:0]                format_q,
  output logic [UNIT_W-1:0]               unit_q,
  output logic [REG_ADDR_W-1:0]           rt_addr_q,
  output logic [IMM_W-1:0]                imm_q,
  output logic                            reg_write_q,
  output logic [DATA_W-1:0]               ra,
  output logic [DATA_W-1:0]               rb,
  output logic [DATA_W-1:0]               rt_st_odd,
  output logic                            out_valid
);

  logic [DATA_W-1:0] rf_q [NUM_REGS];

  odd_bundle_t       bundle_q, bundle_d;
  logic [DATA_W-1:0] ra_q, ra_d, rb_q, rb_d, rc_q, rc_d;
  logic              valid_q, valid_d;
  logic [DATA_W-1:0] ra_c, rb_c, rc_c;

  fwd_select u_sel_ra (
    .addr_i(ra_addr), .fw_wb_i(fw_wb), .fw_addr_wb_i(fw_addr_wb), .fw_write_wb_i(fw_write_wb),
    .wb_data_i(wb_data), .wb_addr_i(wb_addr), .wb_write_i(wb_write),
    .rf_data_i(rf_q[ra_addr]), .data_c(ra_c)
  );

  fwd_select u_sel_rb (
    .addr_i(rb_addr), .fw_wb_i(fw_wb), .fw_addr_wb_i(fw_addr_wb), .fw_write_wb_i(fw_write_wb),
    .wb_data_i(wb_data), .wb_addr_i(wb_addr), .wb_write_i(wb_write),
    .rf_data_i(rf_q[rb_addr]), .data_c(rb_c)
  );

  fwd_select u_sel_rc (
    .addr_i(rc_addr), .fw_wb_i(fw_wb), .fw_addr_wb_i(fw_addr_wb), .fw_write_wb_i(fw_write_wb),
    .wb_data_i(wb_data), .wb_addr_i(wb_addr), .wb_write_i(wb_write),
    .rf_data_i(rf_q[rc_addr]), .data_c(rc_c)
  );

  // Register file: cleared in the reset cycle, written by WB regardless of stall.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(NUM_REGS); i++) begin
        rf_q[i] <= '0;
      end
    end else if (wb_write) begin
      rf_q[wb_addr] <= wb_data;
    end
  end

  // Output bundle next state; a bubble clears the side-effect fields.
  always_comb begin
    bundle_d = bundle_q;
    ra_d     = ra_q;
    rb_d     = rb_q;
    rc_d     = rc_q;
    valid_d  = valid_q;
    if (!stall) begin
      valid_d            = in_valid;
      bundle_d.op        = op;
      bundle_d.format    = format;
      bundle_d.unit      = odd_unit_t'(unit);
      bundle_d.rt_addr   = rt_addr;
      bundle_d.imm       = imm;
      bundle_d.reg_write = reg_write;
      ra_d               = ra_c;
      rb_d               = rb_c;
      rc_d               = rc_c;
      if (!in_valid) begin
        bundle_d.reg_write = 1'b0;
        bundle_d.unit      = UNIT_PERM;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bundle_q <= '0;
      ra_q     <= '0;
      rb_q     <= '0;
      rc_q     <= '0;
      valid_q  <= 1'b0;
    end else begin
      bundle_q <= bundle_d;
      ra_q     <= ra_d;
      rb_q     <= rb_d;
      rc_q     <= rc_d;
      valid_q  <= valid_d;
    end
  end

  assign op_q        = bundle_q.op;
  assign format_q    = bundle_q.format;
  assign unit_q      = UNIT_W'(bundle_q.unit);
  assign rt_addr_q   = bundle_q.rt_addr;
  assign imm_q       = bundle_q.imm;
  assign reg_write_q = bundle_q.reg_write;
  assign ra          = ra_q;
  assign rb          = rb_q;
  assign rt_st_odd   = rc_q;
  assign out_valid   = valid_q;

endmodule

// File: tb/tb_odd_operand_fetch.sv
// Directed bench for odd_operand_fetch; expectations follow ODD_FWD_EN when it is defined.
module tb_odd_operand_fetch;
  import spu_pkg::*;

  logic                            clk = 1'b0;
  logic                            reset, in_valid, stall, reg_write, wb_write;
  logic [OP_W-1:0]                 op;
  logic [FMT_W-1:0]                format;
  logic [UNIT_W-1:0]               unit;
  logic [REG_ADDR_W-1:0]           rt_addr, ra_addr, rb_addr, rc_addr, wb_addr;
  logic [IMM_W-1:0]                imm;
  logic [FWD_DEPTH*DATA_W-1:0]     fw_wb;
  logic [FWD_DEPTH*REG_ADDR_W-1:0] fw_addr_wb;
  logic [FWD_DEPTH-1:0]            fw_write_wb;
  logic [DATA_W-1:0]               wb_data;
  logic [OP_W-1:0]                 op_q;
  logic [FMT_W-1:0]                format_q;
  logic [UNIT_W-1:0]               unit_q;
  logic [REG_ADDR_W-1:0]           rt_addr_q;
  logic [IMM_W-1:0]                imm_q;
  logic                            reg_write_q, out_valid;
  logic [DATA_W-1:0]               ra, rb, rt_st_odd;

  int vectors = 0;
  int miscompares = 0;

  localparam logic [DATA_W-1:0] AA = {16{8'hAA}};

  odd_operand_fetch dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .stall(stall), .op(op), .format(format),
    .unit(unit), .rt_addr(rt_addr), .ra_addr(ra_addr), .rb_addr(rb_addr), .rc_addr(rc_addr),
    .imm(imm), .reg_write(reg_write), .fw_wb(fw_wb), .fw_addr_wb(fw_addr_wb),
    .fw_write_wb(fw_write_wb), .wb_data(wb_data), .wb_addr(wb_addr), .wb_write(wb_write),
    .op_q(op_q), .format_q(format_q), .unit_q(unit_q), .rt_addr_q(rt_addr_q), .imm_q(imm_q),
    .reg_write_q(reg_write_q), .ra(ra), .rb(rb), .rt_st_odd(rt_st_odd), .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [DATA_W-1:0] exp_fwd, exp_rb3;
    // Reset while stalled and writing R5
    reset = 1'b1; stall = 1'b1; in_valid = 1'b1; reg_write = 1'b1;
    op = 11'h7FF; format = 3'd7; unit = 2'd2; rt_addr = 7'd1; imm = 18'h3FFFF;
    ra_addr = 7'd5; rb_addr = 7'd5; rc_addr = 7'd5;
    fw_wb = '0; fw_addr_wb = '0; fw_write_wb = '0;
    wb_write = 1'b1; wb_addr = 7'd5; wb_data = {DATA_W{1'b1}};
    step();
    step();
    check("rst_valid", DATA_W'(out_valid), '0);
    check("rst_ra", ra, '0);
    check("rst_op", DATA_W'(op_q), '0);
    check("rst_regwr", DATA_W'(reg_write_q), '0);
    check("rst_imm", DATA_W'(imm_q), '0);

    reset = 1'b0; stall = 1'b0; wb_write = 1'b0; in_valid = 1'b1; reg_write = 1'b0;
    step();
    check("r5_after_rst", ra, '0);
    check("r5_valid", DATA_W'(out_valid), 128'd1);

    // WB R5, then read next cycle
    wb_write = 1'b1; wb_addr = 7'd5; wb_data = AA; in_valid = 1'b0;
    step();
    wb_write = 1'b0; in_valid = 1'b1; ra_addr = 7'd5;
    op = 11'h123; format = 3'd3; unit = 2'd1; rt_addr = 7'd7; imm = 18'h20001; reg_write = 1'b1;
    step();
    check("rf_read_ra", ra, AA);
    check("rf_read_valid", DATA_W'(out_valid), 128'd1);
    check("op_q", DATA_W'(op_q), 128'h123);
    check("format_q", DATA_W'(format_q), 128'd3);
    check("unit_q", DATA_W'(unit_q), 128'd1);
    check("rt_addr_q", DATA_W'(rt_addr_q), 128'd7);
    check("imm_q", DATA_W'(imm_q), 128'h20001);
    check("reg_write_q", DATA_W'(reg_write_q), 128'd1);

    // Same-cycle WB bypass
    ra_addr = 7'd9; rb_addr = 7'd5; rc_addr = 7'd9;
    wb_write = 1'b1; wb_addr = 7'd9; wb_data = 128'h1234;
    step();
    check("bypass_ra", ra, 128'h1234);
    check("bypass_rb", rb, AA);
    check("bypass_rc", rt_st_odd, 128'h1234);

    // Forwarding: entries 2 and 5 hit R9, entry 0 targets R3, WB writes R9
    wb_data = 128'h77;
    fw_write_wb = 7'b0100101;
    fw_addr_wb[0*REG_ADDR_W +: REG_ADDR_W] = 7'd3;
    fw_addr_wb[2*REG_ADDR_W +: REG_ADDR_W] = 7'd9;
    fw_addr_wb[5*REG_ADDR_W +: REG_ADDR_W] = 7'd9;
    fw_wb[0*DATA_W +: DATA_W] = 128'h99;
    fw_wb[2*DATA_W +: DATA_W] = 128'h22;
    fw_wb[5*DATA_W +: DATA_W] = 128'h55;
    rb_addr = 7'd3;
`ifdef ODD_FWD_EN
    exp_fwd = 128'h22; exp_rb3 = 128'h99;
`else
    exp_fwd = 128'h77; exp_rb3 = 128'h0;
`endif
    step();
    check("fwd_ra", ra, exp_fwd);
    check("fwd_rb", rb, exp_rb3);
    check("fwd_rc", rt_st_odd, exp_fwd);

    fw_write_wb = '0; wb_write = 1'b0;
    step();
    check("rf_r9", ra, 128'h77);

    // Stall holds bundle while RF keeps updating
    ra_addr = 7'd5; op = 11'h055; in_valid = 1'b1;
    step();
    check("pre_stall_ra", ra, AA);
    stall = 1'b1; ra_addr = 7'd9; op = 11'h7FF;
    wb_write = 1'b1; wb_addr = 7'd5; wb_data = 128'h5555;
    for (int c = 0; c < 3; c++) begin
      in_valid = c[0];
      step();
      wb_write = 1'b0;
      check("stall_ra", ra, AA);
      check("stall_op", DATA_W'(op_q), 128'h055);
      check("stall_valid", DATA_W'(out_valid), 128'd1);
    end
    stall = 1'b0; in_valid = 1'b1; ra_addr = 7'd5;
    step();
    check("post_stall_ra", ra, 128'h5555);

    // Bubble clears reg_write_q and unit_q
    in_valid = 1'b0; reg_write = 1'b1; unit = 2'd2;
    step();
    check("bubble_valid", DATA_W'(out_valid), '0);
    check("bubble_regwr", DATA_W'(reg_write_q), '0);
    check("bubble_unit", DATA_W'(unit_q), '0);

    // Reset mid-stall with WB active
    in_valid = 1'b1;
    step();
    stall = 1'b1; reset = 1'b1; wb_write = 1'b1; wb_addr = 7'd5; wb_data = AA;
    step();
    check("midrst_valid", DATA_W'(out_valid), '0);
    check("midrst_ra", ra, '0);
    reset = 1'b0; stall = 1'b0; wb_write = 1'b0; ra_addr = 7'd5;
    step();
    check("midrst_r5", ra, '0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
